// File: rtl/sos_stream_driver.sv
// sos_stream_driver: initiator-side driver for one biquad SOS stage.
// Buffers Q2.14 samples in a small FIFO. Issues them to the stage one at a
// time and returns each result on a valid/ready sink. Holds the stage
// coefficients in a double-buffered bank that swaps only between samples.
// Optional feature macro: SOS_DRV_TIMEOUT_EN. When it is defined, WAIT
// abandons a sample after TIMEOUT cycles without a result.
`timescale 1ns/1ps
module sos_stream_driver #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              coef_wr,
  input  logic [2:0]        coef_addr,
  input  logic [DATA_W-1:0] coef_wdata,
  input  logic              coef_commit,
  output logic              stg_valid,
  output logic [DATA_W-1:0] stg_data,
  output logic [DATA_W-1:0] stg_b0,
  output logic [DATA_W-1:0] stg_b1,
  output logic [DATA_W-1:0] stg_b2,
  output logic [DATA_W-1:0] stg_a1,
  output logic [DATA_W-1:0] stg_a2,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              timeout_err,
  output logic              proto_err,
  input  logic              err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Catch illegal configurations at elaboration time.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("sos_stream_driver: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              fifo_empty, fifo_full, push, pop;
  logic [DATA_W-1:0] shadow [5];
  logic [DATA_W-1:0] shadow_next [5];
  logic [DATA_W-1:0] active [5];
  logic              commit_pending;
  logic              start_issue;
  logic              proto_set;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  // s_ready depends only on the registered fill level, so a same-cycle pop never re-opens a full FIFO.
  assign s_ready    = !fifo_full;
  assign push       = s_valid && !fifo_full;
  assign pop        = (state == ISSUE);
  assign busy       = (state != IDLE) || !fifo_empty;

  // The sink must be free (or freeing this cycle) before another sample may start.
  assign start_issue = (state == IDLE) && !fifo_empty && (!m_valid || m_ready);
  assign proto_set   = res_valid && (state != WAIT);

  assign stg_b0 = active[0];
  assign stg_b1 = active[1];
  assign stg_b2 = active[2];
  assign stg_a1 = active[3];
  assign stg_a2 = active[4];

  // FIFO storage and pointers; pointers wrap naturally because the depth is a power of 2.
  // NOTE: the sample storage has no reset; the fill count alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s_data;
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every block samples pre-edge values.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next shadow bank: this cycle's write applied, so a same-cycle commit includes it.
  // NOTE: the whole array gets a default first, so no latch is inferred for unwritten entries.
  always_comb begin
    shadow_next = shadow;
    if (coef_wr) begin
      case (coef_addr)
        3'd0:    shadow_next[0] = coef_wdata;
        3'd1:    shadow_next[1] = coef_wdata;
        3'd2:    shadow_next[2] = coef_wdata;
        3'd3:    shadow_next[3] = coef_wdata;
        3'd4:    shadow_next[4] = coef_wdata;
        default: ;
      endcase
    end
  end

  // Shadow bank register; it resets to the passthrough set (b0 = 1.0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow[0] <= DATA_W'(16'h4000);
      for (int k = 1; k < 5; k++) shadow[k] <= '0;
    end else begin
      shadow <= shadow_next;
    end
  end

`ifdef SOS_DRV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
  logic          tmo_set;
  assign tmo_set = (state == WAIT) && !res_valid && (tmo_cnt == CW'(TIMEOUT - 1));
`else
  assign timeout_err = 1'b0;
`endif

  // Issue/wait FSM; it also owns the active coefficients, the output registers and the sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      stg_valid      <= 1'b0;
      stg_data       <= '0;
      m_valid        <= 1'b0;
      m_data         <= '0;
      proto_err      <= 1'b0;
      commit_pending <= 1'b0;
      active[0]      <= DATA_W'(16'h4000);
      for (int k = 1; k < 5; k++) active[k] <= '0;
`ifdef SOS_DRV_TIMEOUT_EN
      tmo_cnt        <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      stg_valid <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      // A set in the same cycle as err_clr wins.
      proto_err <= proto_set || (proto_err && !err_clr);
`ifdef SOS_DRV_TIMEOUT_EN
      timeout_err <= tmo_set || (timeout_err && !err_clr);
`endif
      // A commit arriving on the swap edge is taken by that swap instead of staying pending.
      if (start_issue)      commit_pending <= 1'b0;
      else if (coef_commit) commit_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (start_issue) begin
            state <= ISSUE;
            if (commit_pending || coef_commit) active <= shadow_next;
          end
        end
        ISSUE: begin
          stg_valid <= 1'b1;
          stg_data  <= fifo_mem[rd_ptr];
          state     <= WAIT;
`ifdef SOS_DRV_TIMEOUT_EN
          tmo_cnt   <= '0;
`endif
        end
        WAIT: begin
          if (res_valid) begin
            m_data  <= res_data;
            m_valid <= 1'b1;
            state   <= IDLE;
          end
`ifdef SOS_DRV_TIMEOUT_EN
          else if (tmo_set) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sos_stream_driver.sv
// Testbench for sos_stream_driver. It uses a stage stub that echoes each
// issued sample 7 cycles later, a vector table for coefficient banking and
// passthrough, and hand-written sequences for backpressure, FIFO fill,
// protocol errors and, when SOS_DRV_TIMEOUT_EN is defined, timeout.
`timescale 1ns/1ps
module tb_sos_stream_driver;
  localparam int DW   = 16;
  localparam int TMO  = 31;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          coef_wr, coef_commit;
  logic [2:0]    coef_addr;
  logic [DW-1:0] coef_wdata;
  logic          stg_valid;
  logic [DW-1:0] stg_data, stg_b0, stg_b1, stg_b2, stg_a1, stg_a2;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic          busy, timeout_err, proto_err, err_clr;

  logic          stub_en, tb_res_valid;
  logic [DW-1:0] tb_res_data, stub_data;
  logic [3:0]    stub_cnt;

  int checks = 0;
  int errors = 0;
  int stg_pulses = 0;
  logic [DW-1:0] issued[$];
  logic [DW-1:0] results[$];

  sos_stream_driver #(.DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_commit(coef_commit),
    .stg_valid(stg_valid), .stg_data(stg_data), .stg_b0(stg_b0), .stg_b1(stg_b1),
    .stg_b2(stg_b2), .stg_a1(stg_a1), .stg_a2(stg_a2), .res_valid(res_valid),
    .res_data(res_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .timeout_err(timeout_err), .proto_err(proto_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Stage stub: responds 7 cycles after the issue pulse when enabled.
  assign res_valid = tb_res_valid || (stub_en && stub_cnt == 4'd1);
  assign res_data  = tb_res_valid ? tb_res_data : stub_data;

  always @(posedge clk) begin
    if (!rst_n) begin
      stub_cnt <= '0;
    end else if (stg_valid) begin
      stub_cnt  <= 4'd7;
      stub_data <= stg_data;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1'b1;
    end
  end

  // Monitor: counts issue pulses and records issued samples and delivered results.
  always @(negedge clk) begin
    if (rst_n && stg_valid) begin
      stg_pulses <= stg_pulses + 1;
      issued.push_back(stg_data);
    end
    if (rst_n && m_valid && m_ready) results.push_back(m_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; coef_wr = 1'b0; coef_addr = '0;
    coef_wdata = '0; coef_commit = 1'b0; m_ready = 1'b1; err_clr = 1'b0;
    tb_res_valid = 1'b0; tb_res_data = '0; stub_en = 1'b1;
    tick();
    tick();
    issued.delete();
    results.delete();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(input string name);
    int n = 0;
    while (!m_valid && n < 40) begin
      tick();
      n++;
    end
    check(name, m_valid, 1'b1);
  endtask

  typedef struct {
    logic          wr;
    logic [2:0]    addr;
    logic [DW-1:0] wdata;
    logic          commit;
    logic [DW-1:0] sample;
    logic [DW-1:0] exp_b0, exp_b1, exp_b2, exp_a1, exp_a2;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int p0, n, accepted;
    bit stable;
    logic [DW-1:0] held;

    vecs[0] = '{1'b1, 3'd1, 16'h1111, 1'b1, 16'h7FFF, 16'h4000, 16'h1111, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 3'd2, 16'h2222, 1'b0, 16'h8000, 16'h4000, 16'h1111, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{1'b1, 3'd4, 16'h5555, 1'b1, 16'h0001, 16'h4000, 16'h1111, 16'h2222, 16'h0000, 16'h5555};
    vecs[3] = '{1'b1, 3'd6, 16'hFFFF, 1'b1, 16'hFFFF, 16'h4000, 16'h1111, 16'h2222, 16'h0000, 16'h5555};
    vecs[4] = '{1'b1, 3'd0, 16'h2000, 1'b1, 16'h1234, 16'h2000, 16'h1111, 16'h2222, 16'h0000, 16'h5555};
    vecs[5] = '{1'b1, 3'd3, 16'h8001, 1'b0, 16'hC3A5, 16'h2000, 16'h1111, 16'h2222, 16'h0000, 16'h5555};

    // T1: reset values and single-sample latency
    do_reset();
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_stg_valid", stg_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_b0", stg_b0, 16'h4000);
    check("rst_b1", stg_b1, 16'h0000);
    check("rst_b2", stg_b2, 16'h0000);
    check("rst_a1", stg_a1, 16'h0000);
    check("rst_a2", stg_a2, 16'h0000);
    check("rst_errs", {timeout_err, proto_err}, 2'b00);
    push(16'h1000);
    check("t1_stg_t0", stg_valid, 1'b0);
    tick();
    check("t1_stg_t1", stg_valid, 1'b0);
    tick();
    check("t1_stg_t2", stg_valid, 1'b1);
    check("t1_stg_data", stg_data, 16'h1000);
    wait_mvalid("t1_m_valid");
    check("t1_m_data", m_data, 16'h1000);
    tick();
    check("t1_m_clear", m_valid, 1'b0);

    // Table: coefficient banking and bit-exact passthrough
    for (int i = 0; i < 6; i++) begin
      coef_wr = vecs[i].wr; coef_addr = vecs[i].addr;
      coef_wdata = vecs[i].wdata; coef_commit = vecs[i].commit;
      tick();
      coef_wr = 1'b0; coef_commit = 1'b0;
      push(vecs[i].sample);
      tick();
      check($sformatf("vec%0d_b0", i), stg_b0, vecs[i].exp_b0);
      check($sformatf("vec%0d_b1", i), stg_b1, vecs[i].exp_b1);
      check($sformatf("vec%0d_b2", i), stg_b2, vecs[i].exp_b2);
      check($sformatf("vec%0d_a1", i), stg_a1, vecs[i].exp_a1);
      check($sformatf("vec%0d_a2", i), stg_a2, vecs[i].exp_a2);
      wait_mvalid($sformatf("vec%0d_m_valid", i));
      check($sformatf("vec%0d_m_data", i), m_data, vecs[i].sample);
      tick();
    end

    // T3: write+commit during WAIT takes effect only at the next issue
    do_reset();
    push(16'h0A0A);
    tick();
    tick();
    check("t3_in_wait", stg_valid, 1'b1);
    coef_wr = 1'b1; coef_addr = 3'd3; coef_wdata = 16'hC000; coef_commit = 1'b1;
    tick();
    coef_wr = 1'b0; coef_commit = 1'b0;
    check("t3_a1_wait", stg_a1, 16'h0000);
    wait_mvalid("t3_m_valid");
    check("t3_a1_result", stg_a1, 16'h0000);
    tick();
    tick();
    check("t3_a1_idle", stg_a1, 16'h0000);
    push(16'h0B0B);
    tick();
    check("t3_a1_issue", stg_a1, 16'hC000);
    tick();
    check("t3_stg_data", stg_data, 16'h0B0B);
    wait_mvalid("t3_m_valid2");
    tick();

    // T4: sink backpressure holds the result and stalls issue
    do_reset();
    m_ready = 1'b0;
    p0 = stg_pulses;
    push(16'hA001);
    push(16'hB002);
    push(16'hC003);
    wait_mvalid("t4_m_valid");
    check("t4_m_data", m_data, 16'hA001);
    held = m_data;
    stable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (m_data !== held || m_valid !== 1'b1) stable = 1'b0;
    end
    check("t4_held_stable", stable, 1'b1);
    check("t4_single_issue", stg_pulses - p0, 1);
    m_ready = 1'b1;
    n = 0;
    while (results.size() < 3 && n < 100) begin
      tick();
      n++;
    end
    check("t4_result_count", results.size(), 3);
    if (results.size() == 3) begin
      check("t4_res0", results[0], 16'hA001);
      check("t4_res1", results[1], 16'hB002);
      check("t4_res2", results[2], 16'hC003);
    end
    if (issued.size() == 3) check("t4_issue_order", {issued[1], issued[2]}, {16'hB002, 16'hC003});
    else check("t4_issue_count", issued.size(), 3);

    // T6: result pulse outside WAIT is a protocol error; err_clr loses to a same-cycle set
    do_reset();
    tb_res_valid = 1'b1; tb_res_data = 16'hDEAD;
    tick();
    tb_res_valid = 1'b0;
    check("t6_proto_set", proto_err, 1'b1);
    check("t6_m_valid", m_valid, 1'b0);
    tick();
    check("t6_m_valid_later", m_valid, 1'b0);
    err_clr = 1'b1; tb_res_valid = 1'b1;
    tick();
    tb_res_valid = 1'b0;
    check("t6_set_wins", proto_err, 1'b1);
    tick();
    err_clr = 1'b0;
    check("t6_cleared", proto_err, 1'b0);

    // T2: silent stage, FIFO fills after 4 held + 1 popped; then reset mid-WAIT
    do_reset();
    stub_en = 1'b0;
    p0 = stg_pulses;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data = DW'(16'h0100 + i);
      if (s_ready) accepted++;
      tick();
    end
    s_valid = 1'b0;
    check("t2_accepted", accepted, 5);
    check("t2_s_ready", s_ready, 1'b0);
    check("t2_busy", busy, 1'b1);
    check("t2_one_issue", stg_pulses - p0, 1);
`ifndef SOS_DRV_TIMEOUT_EN
    for (int i = 0; i < 40; i++) tick();
    check("t2_still_one_issue", stg_pulses - p0, 1);
`endif
    rst_n = 1'b0;
    tick();
    check("t2_rst_s_ready", s_ready, 1'b1);
    check("t2_rst_busy", busy, 1'b0);
    check("t2_rst_stg_valid", stg_valid, 1'b0);
    rst_n = 1'b1;
    stub_en = 1'b1;

`ifdef SOS_DRV_TIMEOUT_EN
    // T5: timeout abandons the sample, the next one issues, err_clr clears the flag
    do_reset();
    stub_en = 1'b0;
    push(16'h5A5A);
    push(16'h6B6B);
    n = 0;
    while (!stg_valid && n < 10) begin
      tick();
      n++;
    end
    check("t5_first_issue", stg_valid, 1'b1);
    n = 0;
    while (!timeout_err && n < 100) begin
      tick();
      n++;
    end
    check("t5_timeout_delay", n, TMO);
    check("t5_no_output", m_valid, 1'b0);
    n = 0;
    while (!stg_valid && n < 10) begin
      tick();
      n++;
    end
    check("t5_next_issue", stg_valid, 1'b1);
    check("t5_next_data", stg_data, 16'h6B6B);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5_cleared", timeout_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
